// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for pipeline stage registers: stall indices, NOP payload, FSM and delay-slot encodings.
// No logic or latency of its own.
// No flow control; constants only.
package pipe_stage_reg_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [2:0] EXE_RES_NOP = 3'b000;

  // ID/EX layout: aluop(8) alusel(3) reg1(32) reg2(32) wd(5) wreg(1)
  localparam int ID_EX_W = 81;
  localparam logic [ID_EX_W-1:0] ID_EX_NOP_PAYLOAD = {EXE_NOP_OP, EXE_RES_NOP, 70'b0};

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_ILLEGAL
  } act_t;

  localparam logic NOT_IN_DELAY_SLOT = 1'b0;
  localparam logic IN_DELAY_SLOT     = 1'b1;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Count visible one cycle after inc.
// No backpressure; inc ignored once saturated.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline register between stages SRC_IDX/DST_IDX with flush, bubble, delay-slot retention, sticky stall_err.
// Latency 1 cycle; perf counters built only with PIPE_STAGE_PERF_CNT_EN defined.
// Stall: s&~d inserts a bubble, d holds contents; ~s&d is illegal and also holds.
import pipe_stage_reg_pkg::*;

module pipe_stage_reg #(
  parameter int                 DATA_W      = 81,
  parameter int                 ADDR_W      = 32,
  parameter int                 STALL_W     = 6,
  parameter int                 SRC_IDX     = STALL_ID,
  parameter int                 DST_IDX     = STALL_EX,
  parameter logic [DATA_W-1:0]  NOP_PAYLOAD = DATA_W'(ID_EX_NOP_PAYLOAD),
  parameter int                 CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_payload,
  input  logic               in_is_in_delayslot,
  input  logic [ADDR_W-1:0]  in_link_address,
  input  logic               next_inst_in_delayslot_i,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_payload,
  output logic               out_is_in_delayslot,
  output logic [ADDR_W-1:0]  out_link_address,
  output logic               is_in_delayslot_o,
  output logic               stall_err,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt
);

  state_t state, state_nxt;
  act_t   act;
  logic   s, d;

  // Only the two selected stall bits matter; the rest are intentionally dropped.
  logic   stall_unused;
  assign stall_unused = ^stall;

  assign s = stall[SRC_IDX];
  assign d = stall[DST_IDX];

  always_comb begin
    act = ACT_HOLD;
    if (flush) begin
      act = ACT_FLUSH;
    end else begin
      case ({s, d})
        2'b10:   act = ACT_BUBBLE;
        2'b00:   act = ACT_ADVANCE;
        2'b11:   act = ACT_HOLD;
        default: act = ACT_ILLEGAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (act)
      ACT_FLUSH, ACT_BUBBLE: state_nxt = ST_EMPTY;
      ACT_ADVANCE:           state_nxt = in_valid ? ST_FULL : ST_EMPTY;
      default:               state_nxt = state;
    endcase
  end

  always_comb begin
    out_valid = (state == ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_payload         <= NOP_PAYLOAD;
      out_is_in_delayslot <= NOT_IN_DELAY_SLOT;
      out_link_address    <= '0;
      is_in_delayslot_o   <= NOT_IN_DELAY_SLOT;
    end else begin
      case (act)
        ACT_FLUSH: begin
          out_payload         <= NOP_PAYLOAD;
          out_is_in_delayslot <= NOT_IN_DELAY_SLOT;
          out_link_address    <= '0;
          is_in_delayslot_o   <= NOT_IN_DELAY_SLOT;
        end
        // is_in_delayslot_o is left alone so a branch's slot survives the bubble.
        ACT_BUBBLE: begin
          out_payload         <= NOP_PAYLOAD;
          out_is_in_delayslot <= NOT_IN_DELAY_SLOT;
          out_link_address    <= '0;
        end
        ACT_ADVANCE: begin
          out_payload         <= in_payload;
          out_is_in_delayslot <= in_is_in_delayslot;
          out_link_address    <= in_link_address;
          is_in_delayslot_o   <= next_inst_in_delayslot_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_err <= 1'b0;
    end else if (act == ACT_ILLEGAL) begin
      stall_err <= 1'b1;
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic bubble_inc, hold_inc;
  assign bubble_inc = (act == ACT_BUBBLE);
  assign hold_inc   = (act == ACT_HOLD) || (act == ACT_ILLEGAL);

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (bubble_inc),
    .cnt   (bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (hold_inc),
    .cnt   (hold_cnt)
  );
`else
  assign bubble_cnt = '0;
  assign hold_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps then random traffic against a cycle-level reference model.
// Counter expectations follow PIPE_STAGE_PERF_CNT_EN.
module tb_pipe_stage_reg;

  localparam int DATA_W = 81;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  logic               clk;
  logic               rst;
  logic [5:0]         stall;
  logic               flush;
  logic               in_valid;
  logic [DATA_W-1:0]  in_payload;
  logic               in_is_in_delayslot;
  logic [ADDR_W-1:0]  in_link_address;
  logic               next_inst_in_delayslot_i;
  logic               out_valid;
  logic [DATA_W-1:0]  out_payload;
  logic               out_is_in_delayslot;
  logic [ADDR_W-1:0]  out_link_address;
  logic               is_in_delayslot_o;
  logic               stall_err;
  logic [CNT_W-1:0]   bubble_cnt;
  logic [CNT_W-1:0]   hold_cnt;

  pipe_stage_reg #(.CNT_W(CNT_W)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .stall                    (stall),
    .flush                    (flush),
    .in_valid                 (in_valid),
    .in_payload               (in_payload),
    .in_is_in_delayslot       (in_is_in_delayslot),
    .in_link_address          (in_link_address),
    .next_inst_in_delayslot_i (next_inst_in_delayslot_i),
    .out_valid                (out_valid),
    .out_payload              (out_payload),
    .out_is_in_delayslot      (out_is_in_delayslot),
    .out_link_address         (out_link_address),
    .is_in_delayslot_o        (is_in_delayslot_o),
    .stall_err                (stall_err),
    .bubble_cnt               (bubble_cnt),
    .hold_cnt                 (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what the stage should hold, plus raw (unbounded) event counts.
  logic              m_valid;
  logic [DATA_W-1:0] m_payload;
  logic              m_ds;
  logic [ADDR_W-1:0] m_link;
  logic              m_ds_o;
  logic              m_err;
  int                m_bubbles;
  int                m_holds;

  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
    int cap;
    cap = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_PERF_CNT_EN
    return CNT_W'((n > cap) ? cap : n);
`else
    return CNT_W'(0 * n);
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic s, d;
    s = stall[2];
    d = stall[3];
    if (rst) begin
      m_valid = 0; m_payload = '0; m_ds = 0; m_link = '0; m_ds_o = 0;
      m_err = 0; m_bubbles = 0; m_holds = 0;
    end else if (flush) begin
      m_valid = 0; m_payload = '0; m_ds = 0; m_link = '0; m_ds_o = 0;
    end else if (s && !d) begin
      m_valid = 0; m_payload = '0; m_ds = 0; m_link = '0;
      m_bubbles++;
    end else if (!s && !d) begin
      m_valid = in_valid; m_payload = in_payload; m_ds = in_is_in_delayslot;
      m_link = in_link_address; m_ds_o = next_inst_in_delayslot_i;
    end else begin
      m_holds++;
      if (!s) m_err = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},   128'(out_valid),           128'(m_valid));
    chk({tag, ".payload"}, 128'(out_payload),         128'(m_payload));
    chk({tag, ".ds"},      128'(out_is_in_delayslot), 128'(m_ds));
    chk({tag, ".link"},    128'(out_link_address),    128'(m_link));
    chk({tag, ".ds_o"},    128'(is_in_delayslot_o),   128'(m_ds_o));
    chk({tag, ".err"},     128'(stall_err),           128'(m_err));
    chk({tag, ".bubble"},  128'(bubble_cnt),          128'(exp_cnt(m_bubbles)));
    chk({tag, ".hold"},    128'(hold_cnt),            128'(exp_cnt(m_holds)));
  endtask

  task automatic rand_data();
    in_valid                 = 1'($urandom);
    in_payload               = DATA_W'({$urandom, $urandom, $urandom});
    in_is_in_delayslot       = 1'($urandom);
    in_link_address          = $urandom;
    next_inst_in_delayslot_i = 1'($urandom);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1; flush = 0; stall = 6'($urandom); rand_data();

    // Reset with arbitrary inputs
    tick("reset0");
    stall = 6'($urandom); flush = 1'($urandom); rand_data();
    tick("reset1");
    chk("reset.payload_nop", 128'(out_payload), 128'(0));
    rst = 0;

    // Advance of a known value
    stall = 6'b000000; flush = 0; in_valid = 1;
    in_payload = 81'h1_2345_6789_ABCD_EF01_2345;
    in_is_in_delayslot = 1; in_link_address = 32'hDEAD_BEEF;
    next_inst_in_delayslot_i = 1;
    tick("advance");
    chk("advance.ds_o_one", 128'(is_in_delayslot_o), 128'(1));

    // Hold for 3 cycles with changing inputs
    stall = 6'b001111;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      tick("hold");
    end
    chk("hold.payload_kept", 128'(out_payload), 128'(81'h1_2345_6789_ABCD_EF01_2345));

    // Bubble keeps the delay-slot flag
    stall = 6'b000111; rand_data();
    tick("bubble");
    chk("bubble.ds_o_kept", 128'(is_in_delayslot_o), 128'(1));

    // Refill, then flush under a hold pattern
    stall = 6'b000000; rand_data(); in_valid = 1; next_inst_in_delayslot_i = 1;
    tick("refill");
    stall = 6'b001111; flush = 1; rand_data();
    tick("flush");
    flush = 0;

    // Illegal stall, then advance: stall_err stays set
    stall = 6'b001000; rand_data();
    tick("illegal");
    chk("illegal.err_set", 128'(stall_err), 128'(1));
    stall = 6'b000000; rand_data();
    tick("post_illegal");

    // Saturation: 20 bubbles
    stall = 6'b000111;
    for (int i = 0; i < 20; i++) begin
      rand_data();
      tick("sat");
    end

    // Reset asserted mid-hold wins, then resume from empty
    stall = 6'b001111; tick("pre_rst_hold");
    rst = 1; tick("rst_mid_hold");
    rst = 0; stall = 6'b000000; rand_data(); in_valid = 0;
    tick("after_rst");

    // Random traffic, including unrelated stall bits
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 11) == 0);
      stall = 6'($urandom);
      rand_data();
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
